// File: rtl/conv_accel_seq.sv
// conv_accel_seq: memory-mapped KxK-over-NxN valid convolution engine.
// A single saturating multiplier is time-shared over every kernel tap of every
// output. After the MAC pass the block averages the MxM outputs, then
// rewrites each output as max(r - avg, 0) while accumulating a variance figure.
// Optional feature macro: CONV_ACCEL_VAR_EN builds the variance squarer and
// accumulator. Without it VAR reads 0, and the NORM pass still runs so that
// the cycle count is the same in both builds.
module conv_accel_seq #(
  parameter int DW = 8,
  parameter int K  = 3,
  parameter int N  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic        accel_select,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [15:0] ctr
);

  localparam int M   = N - K + 1;
  localparam int KK  = K * K;
  localparam int NN  = N * N;
  localparam int MM  = M * M;
  localparam int LG  = $clog2(MM);
  localparam int SW  = DW + LG;
  localparam int KIW = (KK > 1) ? $clog2(KK) : 1;
  localparam int NIW = (NN > 1) ? $clog2(NN) : 1;
  localparam int MIW = (MM > 1) ? $clog2(MM) : 1;

  localparam logic [DW-1:0]  MAX_VAL   = {DW{1'b1}};
  localparam logic [7:0]     K_LAST    = 8'(K - 1);
  localparam logic [7:0]     M_LAST    = 8'(M - 1);
  localparam logic [MIW-1:0] NORM_LAST = MIW'(MM - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_AVG  = 2'd2;
  localparam logic [1:0] ST_NORM = 2'd3;

  // Architectural state
  logic [1:0]     state_q, state_d;
  logic           done_q, done_d;
  logic [15:0]    counter_q, counter_d;
  logic [DW-1:0]  avg_q, avg_d;
  logic [DW-1:0]  acc_q, acc_d;
  logic [7:0]     o_row_q, o_row_d;
  logic [7:0]     o_col_q, o_col_d;
  logic [7:0]     k_row_q, k_row_d;
  logic [7:0]     k_col_q, k_col_d;
  logic [MIW-1:0] norm_idx_q, norm_idx_d;
  logic [DW-1:0]  kernel_q [KK];
  logic [DW-1:0]  kernel_d [KK];
  logic [DW-1:0]  image_q  [NN];
  logic [DW-1:0]  image_d  [NN];
  logic [DW-1:0]  result_q [MM];
  logic [DW-1:0]  result_d [MM];
  logic [31:0]    var_value;

  // Bus decode
  logic [7:0] word;
  logic [5:0] elem_off;
  logic       wr_fire;
  logic       busy;
  logic       accept;
  logic       go;
  logic       ker_hit;
  logic       img_hit;
  logic       res_hit;

  assign word     = addr[9:2];
  assign elem_off = word[5:0];
  assign wr_fire  = wr_en & accel_select;
  assign busy     = (state_q != ST_IDLE);
  assign accept   = wr_fire & ~busy;
  assign go       = accept & (word == 8'h00);
  assign ker_hit  = (word[7:6] == 2'b01) && ({1'b0, elem_off} < 7'(KK));
  assign img_hit  = (word[7:6] == 2'b10) && ({1'b0, elem_off} < 7'(NN));
  assign res_hit  = (word[7:6] == 2'b11) && ({1'b0, elem_off} < 7'(MM));

  logic unused_bits;
  assign unused_bits = ^{addr[31:10], addr[1:0], data_in[31:DW]};

  // MAC datapath: address the current tap and output, then saturate the
  // product and the running sum independently.
  logic [7:0]      img_lin, ker_lin, res_lin;
  logic [NIW-1:0]  img_idx;
  logic [KIW-1:0]  ker_idx;
  logic [MIW-1:0]  res_idx;
  logic [DW-1:0]   mac_a, mac_b;
  logic [2*DW-1:0] prod_full;
  logic [DW-1:0]   prod_sat;
  logic [DW:0]     sum_full;
  logic [DW-1:0]   sum_sat;

  assign img_lin   = (o_row_q + k_row_q) * 8'(N) + o_col_q + k_col_q;
  assign ker_lin   = k_row_q * 8'(K) + k_col_q;
  assign res_lin   = o_row_q * 8'(M) + o_col_q;
  assign img_idx   = NIW'(img_lin);
  assign ker_idx   = KIW'(ker_lin);
  assign res_idx   = MIW'(res_lin);
  assign mac_a     = kernel_q[ker_idx];
  assign mac_b     = image_q[img_idx];
  assign prod_full = {{DW{1'b0}}, mac_a} * {{DW{1'b0}}, mac_b};
  assign prod_sat  = (|prod_full[2*DW-1:DW]) ? MAX_VAL : prod_full[DW-1:0];
  assign sum_full  = {1'b0, acc_q} + {1'b0, prod_sat};
  assign sum_sat   = sum_full[DW] ? MAX_VAL : sum_full[DW-1:0];

  // Sum every stored result so the AVG state can capture the mean in one cycle
  logic [SW-1:0] res_total;
  logic [DW-1:0] avg_calc;

  always_comb begin
    res_total = '0;
    for (int i = 0; i < MM; i++) begin
      res_total = res_total + SW'(result_q[i]);
    end
  end

  assign avg_calc = DW'(res_total >> LG);

  // Normalisation datapath: absolute distance of the current result from avg
  logic [DW-1:0] norm_r;
  logic          norm_gt;
  logic [DW-1:0] norm_diff;

  assign norm_r    = result_q[norm_idx_q];
  assign norm_gt   = norm_r > avg_q;
  assign norm_diff = norm_gt ? (norm_r - avg_q) : (avg_q - norm_r);

`ifdef CONV_ACCEL_VAR_EN
  logic [31:0]     var_q, var_d;
  logic [2*DW-1:0] norm_sq;

  assign norm_sq   = {{DW{1'b0}}, norm_diff} * {{DW{1'b0}}, norm_diff};
  assign var_value = var_q;
`else
  assign var_value = 32'd0;
`endif

  // Host writes into kernel and image memories, only accepted while idle
  always_comb begin
    kernel_d = kernel_q;
    image_d  = image_q;
    if (accept && ker_hit) begin
      kernel_d[KIW'(elem_off)] = data_in[DW-1:0];
    end
    if (accept && img_hit) begin
      image_d[NIW'(elem_off)] = data_in[DW-1:0];
    end
  end

  // Sequencer: MAC over every tap of every output, one AVG cycle, then NORM
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    counter_d  = counter_q;
    avg_d      = avg_q;
    acc_d      = acc_q;
    o_row_d    = o_row_q;
    o_col_d    = o_col_q;
    k_row_d    = k_row_q;
    k_col_d    = k_col_q;
    norm_idx_d = norm_idx_q;
    result_d   = result_q;
`ifdef CONV_ACCEL_VAR_EN
    var_d      = var_q;
`endif
    if (busy) begin
      counter_d = counter_q + 16'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d    = ST_MAC;
          done_d     = 1'b0;
          counter_d  = '0;
          acc_d      = '0;
          o_row_d    = '0;
          o_col_d    = '0;
          k_row_d    = '0;
          k_col_d    = '0;
          norm_idx_d = '0;
`ifdef CONV_ACCEL_VAR_EN
          var_d      = '0;
`endif
        end
      end
      ST_MAC: begin
        acc_d = sum_sat;
        if (k_col_q == K_LAST) begin
          k_col_d = '0;
          if (k_row_q == K_LAST) begin
            k_row_d           = '0;
            result_d[res_idx] = sum_sat;
            acc_d             = '0;
            if (o_col_q == M_LAST) begin
              o_col_d = '0;
              if (o_row_q == M_LAST) begin
                o_row_d = '0;
                state_d = ST_AVG;
              end else begin
                o_row_d = o_row_q + 8'd1;
              end
            end else begin
              o_col_d = o_col_q + 8'd1;
            end
          end else begin
            k_row_d = k_row_q + 8'd1;
          end
        end else begin
          k_col_d = k_col_q + 8'd1;
        end
      end
      ST_AVG: begin
        avg_d      = avg_calc;
        norm_idx_d = '0;
        state_d    = ST_NORM;
      end
      ST_NORM: begin
        result_d[norm_idx_q] = norm_gt ? norm_diff : '0;
`ifdef CONV_ACCEL_VAR_EN
        var_d = var_q + 32'(norm_sq >> 2);
`endif
        if (norm_idx_q == NORM_LAST) begin
          norm_idx_d = '0;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          norm_idx_d = norm_idx_q + MIW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset wipes memories so nothing survives an abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      counter_q  <= '0;
      avg_q      <= '0;
      acc_q      <= '0;
      o_row_q    <= '0;
      o_col_q    <= '0;
      k_row_q    <= '0;
      k_col_q    <= '0;
      norm_idx_q <= '0;
      kernel_q   <= '{default: '0};
      image_q    <= '{default: '0};
      result_q   <= '{default: '0};
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      counter_q  <= counter_d;
      avg_q      <= avg_d;
      acc_q      <= acc_d;
      o_row_q    <= o_row_d;
      o_col_q    <= o_col_d;
      k_row_q    <= k_row_d;
      k_col_q    <= k_col_d;
      norm_idx_q <= norm_idx_d;
      kernel_q   <= kernel_d;
      image_q    <= image_d;
      result_q   <= result_d;
    end
  end

`ifdef CONV_ACCEL_VAR_EN
  // Variance accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      var_q <= '0;
    end else begin
      var_q <= var_d;
    end
  end
`endif

  // Combinational read mux over the word map; unmapped words read 0
  always_comb begin
    data_out = '0;
    case (word[7:6])
      2'b00: begin
        case (elem_off)
          6'd0:    data_out = {done_q, 29'b0, busy, 1'b0};
          6'd1:    data_out = {16'b0, counter_q};
          6'd2:    data_out = 32'(avg_q);
          6'd3:    data_out = var_value;
          default: data_out = '0;
        endcase
      end
      2'b01: if (ker_hit) data_out = 32'(kernel_q[KIW'(elem_off)]);
      2'b10: if (img_hit) data_out = 32'(image_q[NIW'(elem_off)]);
      2'b11: if (res_hit) data_out = 32'(result_q[MIW'(elem_off)]);
      default: data_out = '0;
    endcase
  end

  assign ctr = counter_q;

endmodule

// File: tb/tb_conv_accel_seq.sv
// tb_conv_accel_seq: randomized and directed bench for conv_accel_seq at its
// default parameters, checked against an arithmetic reference model.
module tb_conv_accel_seq;

  localparam int DW       = 8;
  localparam int K        = 3;
  localparam int N        = 4;
  localparam int M        = N - K + 1;
  localparam int KK       = K * K;
  localparam int NN       = N * N;
  localparam int MM       = M * M;
  localparam int MAC_CYC  = MM * KK;
  localparam int BUSY_CYC = MAC_CYC + 1 + MM;
  localparam int MAXV     = (1 << DW) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        wr_en;
  logic        accel_select;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [15:0] ctr;

  int checks_total  = 0;
  int checks_passed = 0;

  int          kern [KK];
  int          img  [NN];
  int          pre  [MM];
  int          post [MM];
  int          avg_exp;
  logic [31:0] var_exp;

  conv_accel_seq #(.DW(DW), .K(K), .N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .wr_en        (wr_en),
    .accel_select (accel_select),
    .data_in      (data_in),
    .data_out     (data_out),
    .ctr          (ctr)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  task automatic readWord(input logic [7:0] word, output logic [31:0] val);
    addr = {22'd0, word, 2'b00};
    #1;
    val = data_out;
  endtask

  task automatic driveWrite(input logic [7:0] word, input logic [31:0] val);
    addr         = {22'd0, word, 2'b00};
    data_in      = val;
    wr_en        = 1'b1;
    accel_select = 1'b1;
  endtask

  task automatic writeWord(input logic [7:0] word, input logic [31:0] val);
    @(negedge clk);
    driveWrite(word, val);
    @(posedge clk);
    #1;
    wr_en        = 1'b0;
    accel_select = 1'b0;
  endtask

  // Reference model: convolution with per-product and per-sum saturation,
  // integer mean, then distance-from-mean rules.
  task automatic computeModel();
    int total;
    longint var_acc;
    total = 0;
    for (int orow = 0; orow < M; orow++) begin
      for (int ocol = 0; ocol < M; ocol++) begin
        int s;
        s = 0;
        for (int kr = 0; kr < K; kr++) begin
          for (int kc = 0; kc < K; kc++) begin
            int p;
            p = kern[kr*K + kc] * img[(orow + kr)*N + ocol + kc];
            if (p > MAXV) p = MAXV;
            s = s + p;
            if (s > MAXV) s = MAXV;
          end
        end
        pre[orow*M + ocol] = s;
        total += s;
      end
    end
    avg_exp = total / MM;
    var_acc = 0;
    for (int o = 0; o < MM; o++) begin
      int d;
      d = (pre[o] > avg_exp) ? pre[o] - avg_exp : avg_exp - pre[o];
      var_acc += (d * d) / 4;
      post[o] = (pre[o] > avg_exp) ? pre[o] - avg_exp : 0;
    end
`ifdef CONV_ACCEL_VAR_EN
    var_exp = var_acc[31:0];
`else
    var_exp = 32'd0;
`endif
  endtask

  task automatic applyStimulus(input string tag);
    logic [31:0] v;
    int pick;
    for (int i = 0; i < KK; i++) writeWord(8'(8'h40 + i), 32'(kern[i]));
    for (int i = 0; i < NN; i++) writeWord(8'(8'h80 + i), 32'(img[i]));
    @(negedge clk);
    pick = $urandom_range(NN - 1);
    readWord(8'(8'h80 + pick), v);
    checkOutput({tag, " img readback"}, v, 32'(img[pick]));
    readWord(8'(8'h40 + KK - 1), v);
    checkOutput({tag, " ker readback"}, v, 32'(kern[KK-1]));
  endtask

  // Issue go and step the run cycle by cycle, checking at fixed cycle marks
  task automatic runOp(input string tag, input bit intrude, input bit abort_run);
    logic [31:0] v;
    int cyc;
    computeModel();
    writeWord(8'h00, 32'h1);
    cyc = 1;
    while (cyc <= BUSY_CYC + 1) begin
      @(negedge clk);
      if (cyc == 1) begin
        readWord(8'h00, v); checkOutput({tag, " ctrl busy"}, v, 32'h2);
        readWord(8'h01, v); checkOutput({tag, " cycles start"}, v, 32'd0);
      end
      if (intrude && cyc == 10) driveWrite(8'h80, 32'd200);
      if (intrude && cyc == 11) driveWrite(8'h00, 32'h1);
      if (intrude && cyc == 12) begin
        readWord(8'h80, v); checkOutput({tag, " busy write ignored"}, v, 32'(img[0]));
      end
      if (abort_run && cyc == 20) begin
        rst_n = 1'b0;
        readWord(8'h00, v); checkOutput({tag, " abort ctrl"}, v, 32'd0);
        readWord(8'h01, v); checkOutput({tag, " abort cycles"}, v, 32'd0);
        checkOutput({tag, " abort ctr"}, 32'(ctr), 32'd0);
        readWord(8'h40 + 8'd4, v); checkOutput({tag, " abort kernel"}, v, 32'd0);
        readWord(8'h80, v); checkOutput({tag, " abort image"}, v, 32'd0);
        readWord(8'hC0, v); checkOutput({tag, " abort result"}, v, 32'd0);
        rst_n = 1'b1;
        return;
      end
      if (cyc == MAC_CYC + 1) begin
        for (int o = 0; o < MM; o++) begin
          readWord(8'(8'hC0 + o), v);
          checkOutput($sformatf("%s pre res[%0d]", tag, o), v, 32'(pre[o]));
        end
      end
      if (cyc == BUSY_CYC) begin
        readWord(8'h00, v); checkOutput({tag, " ctrl last norm"}, v, 32'h2);
        if (intrude) driveWrite(8'h00, 32'h1);
      end
      if (cyc == BUSY_CYC + 1) begin
        readWord(8'h00, v); checkOutput({tag, " ctrl done"}, v, 32'h8000_0000);
        readWord(8'h01, v); checkOutput({tag, " cycles"}, v, 32'(BUSY_CYC));
        checkOutput({tag, " ctr port"}, 32'(ctr), 32'(BUSY_CYC));
        readWord(8'h02, v); checkOutput({tag, " avg"}, v, 32'(avg_exp));
        readWord(8'h03, v); checkOutput({tag, " var"}, v, var_exp);
        for (int o = 0; o < MM; o++) begin
          readWord(8'(8'hC0 + o), v);
          checkOutput($sformatf("%s post res[%0d]", tag, o), v, 32'(post[o]));
        end
      end
      @(posedge clk);
      #1;
      wr_en        = 1'b0;
      accel_select = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    logic [31:0] v;
    rst_n        = 1'b0;
    addr         = '0;
    wr_en        = 1'b0;
    accel_select = 1'b0;
    data_in      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    readWord(8'h00, v); checkOutput("reset ctrl", v, 32'd0);
    readWord(8'h01, v); checkOutput("reset cycles", v, 32'd0);
    readWord(8'h02, v); checkOutput("reset avg", v, 32'd0);
    readWord(8'h03, v); checkOutput("reset var", v, 32'd0);
    readWord(8'h45, v); checkOutput("reset kernel", v, 32'd0);
    readWord(8'h85, v); checkOutput("reset image", v, 32'd0);
    readWord(8'hC1, v); checkOutput("reset result", v, 32'd0);
    checkOutput("reset ctr", 32'(ctr), 32'd0);
    rst_n = 1'b1;

    $display("[TB] all ones");
    for (int i = 0; i < KK; i++) kern[i] = 1;
    for (int i = 0; i < NN; i++) img[i] = 1;
    applyStimulus("ones");
    runOp("ones", 1'b0, 1'b0);

    $display("[TB] centre tap");
    for (int i = 0; i < KK; i++) kern[i] = (i == 4) ? 1 : 0;
    for (int i = 0; i < NN; i++) img[i] = i;
    applyStimulus("centre");
    runOp("centre", 1'b0, 1'b0);

    $display("[TB] saturation");
    for (int i = 0; i < KK; i++) kern[i] = 16;
    for (int i = 0; i < NN; i++) img[i] = 16;
    applyStimulus("sat");
    runOp("sat", 1'b0, 1'b0);

    $display("[TB] writes while busy");
    for (int i = 0; i < KK; i++) kern[i] = int'($urandom_range(3));
    for (int i = 0; i < NN; i++) img[i] = int'($urandom_range(100));
    applyStimulus("busy");
    runOp("busy", 1'b1, 1'b0);

    $display("[TB] abort by reset");
    for (int i = 0; i < KK; i++) kern[i] = 1;
    for (int i = 0; i < NN; i++) img[i] = int'($urandom_range(50, 1));
    applyStimulus("abort");
    runOp("abort", 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    readWord(8'h00, v); checkOutput("post abort ctrl", v, 32'd0);
    readWord(8'h01, v); checkOutput("post abort cycles", v, 32'd0);
    for (int i = 0; i < KK; i++) kern[i] = int'($urandom_range(7));
    for (int i = 0; i < NN; i++) img[i] = int'($urandom_range(40));
    applyStimulus("fresh");
    runOp("fresh", 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      $display("[TB] random run %0d", r);
      for (int i = 0; i < KK; i++) kern[i] = (r % 2 == 1) ? int'($urandom_range(MAXV)) : int'($urandom_range(3));
      for (int i = 0; i < NN; i++) img[i] = (r % 2 == 1) ? int'($urandom_range(MAXV)) : int'($urandom_range(31));
      applyStimulus($sformatf("rand%0d", r));
      runOp($sformatf("rand%0d", r), 1'b0, 1'b0);
    end

    $display("[TB] idle access rules");
    @(negedge clk);
    addr         = {22'd0, 8'h81, 2'b00};
    data_in      = 32'd77;
    wr_en        = 1'b1;
    accel_select = 1'b0;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    readWord(8'h81, v); checkOutput("unselected write", v, 32'(img[1]));
    writeWord(8'hC0, 32'd123);
    @(negedge clk);
    readWord(8'hC0, v); checkOutput("result read only", v, 32'(post[0]));
    readWord(8'h10, v); checkOutput("unmapped ctrl area", v, 32'd0);
    readWord(8'(8'h40 + KK), v); checkOutput("unmapped kernel", v, 32'd0);
    readWord(8'(8'hC0 + MM), v); checkOutput("unmapped result", v, 32'd0);
    readWord(8'h00, v); checkOutput("done holds", v, 32'h8000_0000);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
